fetch_pc_gen: RTL and testbench
===============================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have ports: clk input 1 clock; rst_n input 1 synchronous active-low reset. Reset rst_n, synchronous, active-low; clock clk.
REQ-003 SHALL have ports: PL_stall input 1 hold pipeline; PL_flush input 1 EX mispredict redirect; flush_target input 32 corrected PC.
REQ-004 SHALL have ports: instr input 32 instruction at pc (combinational from I-mem); B_type_prediction_result input 1 predictor taken/not-taken; jalr_pc_prediction input 32 RAS top.
REQ-005 SHALL have ports: pc output 32 current fetch PC; pc_add_4 output 32 pc+4; imme output 32 decoded immediate of instr.
REQ-006 SHALL have ports: ras_push, ras_pop, ras_rollback_push, ras_rollback_pop output 1 each, RAS controls.
REQ-007 SHALL have ports: pc_id output 32, pred_taken_id output 1, pred_target_id output 32, valid_id output 1, fetch-to-ID pipeline register contents.

Function
REQ-008 SHALL decode instr opcode: 1101111 jal, 1100111 jalr, 1100011 B-type; all else sequential.
REQ-009 SHALL drive imme as sign-extended J-imm for jal, I-imm for jalr, B-imm for B-type, zero otherwise.
REQ-010 SHALL compute next PC by priority: PL_flush -> flush_target; else PL_stall -> pc; else jal -> pc+imme; else jalr -> jalr_pc_prediction; else B-type and B_type_prediction_result=1 -> pc+imme; else pc+4.
REQ-011 SHALL update pc on every rising clk edge with next PC; arithmetic modulo 2^32, no overflow detection (0xFFFF_FFFC+4 = 0).
REQ-012 SHALL assert ras_push combinationally when !PL_stall, !PL_flush, instr is jal/jalr with rd in {x1,x5}.
REQ-013 SHALL assert ras_pop combinationally when !PL_stall, !PL_flush, instr is jalr with rs1 in {x1,x5} and rd not in {x1,x5}.
REQ-014 SHALL register on non-stalled edges: pc_id<=pc, pred_taken_id<=taken decision of REQ-010 (1 for jal/jalr), pred_target_id<=chosen next PC, valid_id<=1, plus internal push_id/pop_id flags.
REQ-015 SHALL, on PL_flush, clear valid_id, pred_taken_id, push_id, pop_id at the edge, regardless of PL_stall.
REQ-016 SHALL, in the flush cycle, assert ras_rollback_pop if valid_id and push_id, and ras_rollback_push if valid_id and pop_id (undo the wrong-path ID op); both outputs 0 otherwise.
REQ-017 SHALL hold all ID registers unchanged while PL_stall and !PL_flush.
REQ-018 SHALL have zero-cycle latency from instr to next-PC choice; one cycle from fetch to ID outputs.

Reset
REQ-019 SHALL, on rst_n=0 at clk edge, set pc=RESET_PC, pc_id=0, pred_target_id=0, pred_taken_id=0, valid_id=0, push_id=0, pop_id=0.
REQ-020 SHALL force ras_push, ras_pop, ras_rollback_push, ras_rollback_pop to 0 while rst_n=0; reset dominates flush and stall.

Structure
REQ-021 SHALL take opcode constants (OP_JAL, OP_JALR, OP_BRANCH) and link-register numbers from the shared define package.
REQ-022 SHALL contain one sub-module fetch_imm_decode (combinational opcode/immediate/link-reg decode); registers live in the top.

Verification
REQ-023 Reset then release, instr=NOP -> pc 0x0, 0x4, 0x8 on successive edges; valid_id rises one cycle after release.
REQ-024 pc=0x100, instr=jal x1,+0x40 -> ras_push=1, next pc=0x140, pred_taken_id=1, pred_target_id=0x140.
REQ-025 pc=0x200, instr=jalr x0,0(x1), jalr_pc_prediction=0x104 -> ras_pop=1, next pc=0x104.
REQ-026 pc=0x300, B-type imm=-8, prediction=1 -> next pc=0x2F8; prediction=0 -> 0x304.
REQ-027 ID holds push (from REQ-024), PL_flush=1, PL_stall=1, flush_target=0x500 -> ras_rollback_pop=1, next pc=0x500, valid_id=0.
REQ-028 PL_stall=1 three cycles -> pc and all ID outputs constant, no RAS strobes; pc=0xFFFF_FFFC sequential -> wraps to 0x0.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch definitions: RV32I control-flow opcodes and link registers.
// Imported by the PC generator and its decoder.
package fetch_pc_gen_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

endpackage

// File: rtl/fetch_imm_decode.sv
// Combinational control-flow decode of the fetched word:
// opcode class, immediate and link-register hints.
module fetch_imm_decode
  import fetch_pc_gen_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        is_branch,
  output logic [31:0] imme,
  output logic        rd_link,
  output logic        rs1_link
);

  logic [6:0] opcode;

  assign opcode    = instr[6:0];
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_branch = (opcode == OP_BRANCH);
  assign rd_link   = is_link(instr[11:7]);
  assign rs1_link  = is_link(instr[19:15]);

  always_comb begin
    imme = '0;
    unique case (1'b1)
      is_jal:
        imme = {{12{instr[31]}}, instr[19:12],
                instr[20], instr[30:21], 1'b0};
      is_jalr:
        imme = {{20{instr[31]}}, instr[31:20]};
      is_branch:
        imme = {{20{instr[31]}}, instr[7],
                instr[30:25], instr[11:8], 1'b0};
      default:
        imme = '0;
    endcase
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator with static jal/jalr/branch prediction,
// RAS push/pop hints and the fetch-to-ID pipeline register.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PL_stall,
  input  logic        PL_flush,
  input  logic [31:0] flush_target,
  input  logic [31:0] instr,
  input  logic        B_type_prediction_result,
  input  logic [31:0] jalr_pc_prediction,
  output logic [31:0] pc,
  output logic [31:0] pc_add_4,
  output logic [31:0] imme,
  output logic        ras_push,
  output logic        ras_pop,
  output logic        ras_rollback_push,
  output logic        ras_rollback_pop,
  output logic [31:0] pc_id,
  output logic        pred_taken_id,
  output logic [31:0] pred_target_id,
  output logic        valid_id
);

  logic        is_jal;
  logic        is_jalr;
  logic        is_branch;
  logic        rd_link;
  logic        rs1_link;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] tgt_id_q, tgt_id_d;
  logic        taken_id_q, taken_id_d;
  logic        valid_id_q, valid_id_d;
  logic        push_id_q, push_id_d;
  logic        pop_id_q, pop_id_d;

  logic        taken;
  logic        push_raw;
  logic        pop_raw;
  logic        issue;
  logic [31:0] pred_pc;

  fetch_imm_decode u_dec (
    .instr     (instr),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .is_branch (is_branch),
    .imme      (imme),
    .rd_link   (rd_link),
    .rs1_link  (rs1_link)
  );

  assign pc       = pc_q;
  assign pc_add_4 = pc_q + 32'd4;

  assign taken    = is_jal | is_jalr |
                    (is_branch & B_type_prediction_result);
  assign push_raw = (is_jal | is_jalr) & rd_link;
  assign pop_raw  = is_jalr & rs1_link & ~rd_link;
  assign issue    = rst_n & ~PL_stall & ~PL_flush;

  assign ras_push = issue & push_raw;
  assign ras_pop  = issue & pop_raw;

  // Undo the RAS effect of the wrong-path op sitting in ID.
  assign ras_rollback_pop  = rst_n & PL_flush &
                             valid_id_q & push_id_q;
  assign ras_rollback_push = rst_n & PL_flush &
                             valid_id_q & pop_id_q;

  always_comb begin
    pred_pc = pc_add_4;
    if (is_jalr)
      pred_pc = jalr_pc_prediction;
    else if (taken)
      pred_pc = pc_q + imme;
  end

  always_comb begin
    pc_d       = pred_pc;
    pc_id_d    = pc_id_q;
    tgt_id_d   = tgt_id_q;
    taken_id_d = taken_id_q;
    valid_id_d = valid_id_q;
    push_id_d  = push_id_q;
    pop_id_d   = pop_id_q;
    if (PL_flush)
      pc_d = flush_target;
    else if (PL_stall)
      pc_d = pc_q;
    if (PL_flush) begin
      valid_id_d = 1'b0;
      taken_id_d = 1'b0;
      push_id_d  = 1'b0;
      pop_id_d   = 1'b0;
      if (!PL_stall) begin
        pc_id_d  = pc_q;
        tgt_id_d = pc_d;
      end
    end else if (!PL_stall) begin
      pc_id_d    = pc_q;
      tgt_id_d   = pc_d;
      taken_id_d = taken;
      valid_id_d = 1'b1;
      push_id_d  = push_raw;
      pop_id_d   = pop_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pc_id_q    <= '0;
      tgt_id_q   <= '0;
      taken_id_q <= 1'b0;
      valid_id_q <= 1'b0;
      push_id_q  <= 1'b0;
      pop_id_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      tgt_id_q   <= tgt_id_d;
      taken_id_q <= taken_id_d;
      valid_id_q <= valid_id_d;
      push_id_q  <= push_id_d;
      pop_id_q   <= pop_id_d;
    end
  end

  assign pc_id          = pc_id_q;
  assign pred_taken_id  = taken_id_q;
  assign pred_target_id = tgt_id_q;
  assign valid_id       = valid_id_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: sequencing, prediction,
// RAS hints, flush rollback, stall hold, wrap and reset.
module tb_fetch_pc_gen;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JAL  = 32'h0400_00EF;
  localparam logic [31:0] RET  = 32'h0000_8067;
  localparam logic [31:0] BEQ  = 32'hFE00_0CE3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PL_stall;
  logic        PL_flush;
  logic [31:0] flush_target;
  logic [31:0] instr;
  logic        B_type_prediction_result;
  logic [31:0] jalr_pc_prediction;
  logic [31:0] pc;
  logic [31:0] pc_add_4;
  logic [31:0] imme;
  logic        ras_push;
  logic        ras_pop;
  logic        ras_rollback_push;
  logic        ras_rollback_pop;
  logic [31:0] pc_id;
  logic        pred_taken_id;
  logic [31:0] pred_target_id;
  logic        valid_id;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .PL_stall                 (PL_stall),
    .PL_flush                 (PL_flush),
    .flush_target             (flush_target),
    .instr                    (instr),
    .B_type_prediction_result (B_type_prediction_result),
    .jalr_pc_prediction       (jalr_pc_prediction),
    .pc                       (pc),
    .pc_add_4                 (pc_add_4),
    .imme                     (imme),
    .ras_push                 (ras_push),
    .ras_pop                  (ras_pop),
    .ras_rollback_push        (ras_rollback_push),
    .ras_rollback_pop         (ras_rollback_pop),
    .pc_id                    (pc_id),
    .pred_taken_id            (pred_taken_id),
    .pred_target_id           (pred_target_id),
    .valid_id                 (valid_id)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    PL_flush     = 1'b1;
    flush_target = t;
    instr        = NOP;
    tick();
    PL_flush     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    PL_stall = 1'b0;
    PL_flush = 1'b0;
    flush_target = '0;
    instr = NOP;
    B_type_prediction_result = 1'b0;
    jalr_pc_prediction = '0;
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, valid_id}, 32'h0);
    check("rst_pc_id", pc_id, 32'h0);
    check("rst_tgt", pred_target_id, 32'h0);
    check("nop_imme", imme, 32'h0);

    rst_n = 1'b1;
    tick();
    check("seq_pc4", pc, 32'h4);
    check("seq_valid", {31'b0, valid_id}, 32'h1);
    check("seq_pc_id", pc_id, 32'h0);
    tick();
    check("seq_pc8", pc, 32'h8);
    check("seq_tgt", pred_target_id, 32'h8);
    check("seq_taken", {31'b0, pred_taken_id}, 32'h0);

    redirect(32'h100);
    check("fl_pc", pc, 32'h100);
    check("fl_valid", {31'b0, valid_id}, 32'h0);
    instr = JAL;
    settle();
    check("jal_imme", imme, 32'h40);
    check("jal_push", {31'b0, ras_push}, 32'h1);
    check("jal_pop", {31'b0, ras_pop}, 32'h0);
    tick();
    check("jal_pc", pc, 32'h140);
    check("jal_taken", {31'b0, pred_taken_id}, 32'h1);
    check("jal_tgt", pred_target_id, 32'h140);
    check("jal_pc_id", pc_id, 32'h100);

    PL_flush = 1'b1;
    PL_stall = 1'b1;
    flush_target = 32'h500;
    settle();
    check("rb_pop", {31'b0, ras_rollback_pop}, 32'h1);
    check("rb_push", {31'b0, ras_rollback_push}, 32'h0);
    check("rb_no_push", {31'b0, ras_push}, 32'h0);
    tick();
    check("rb_pc", pc, 32'h500);
    check("rb_valid", {31'b0, valid_id}, 32'h0);
    check("rb_taken", {31'b0, pred_taken_id}, 32'h0);
    PL_stall = 1'b0;
    PL_flush = 1'b0;

    redirect(32'h200);
    instr = RET;
    jalr_pc_prediction = 32'h104;
    settle();
    check("ret_pop", {31'b0, ras_pop}, 32'h1);
    check("ret_push", {31'b0, ras_push}, 32'h0);
    tick();
    check("ret_pc", pc, 32'h104);
    check("ret_taken", {31'b0, pred_taken_id}, 32'h1);
    PL_flush = 1'b1;
    flush_target = 32'h300;
    instr = NOP;
    settle();
    check("rb2_push", {31'b0, ras_rollback_push}, 32'h1);
    check("rb2_pop", {31'b0, ras_rollback_pop}, 32'h0);
    tick();
    PL_flush = 1'b0;
    check("br_base", pc, 32'h300);

    instr = BEQ;
    B_type_prediction_result = 1'b0;
    settle();
    check("br_imme", imme, 32'hFFFF_FFF8);
    tick();
    check("br_nt_pc", pc, 32'h304);
    check("br_nt_taken", {31'b0, pred_taken_id}, 32'h0);
    check("br_nt_tgt", pred_target_id, 32'h304);
    redirect(32'h300);
    instr = BEQ;
    B_type_prediction_result = 1'b1;
    tick();
    check("br_t_pc", pc, 32'h2F8);
    check("br_t_taken", {31'b0, pred_taken_id}, 32'h1);
    B_type_prediction_result = 1'b0;

    redirect(32'h600);
    tick();
    instr = JAL;
    PL_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("st_push", {31'b0, ras_push}, 32'h0);
      check("st_rb", {30'b0, ras_rollback_push,
                      ras_rollback_pop}, 32'h0);
      tick();
      check("st_pc", pc, 32'h604);
      check("st_pc_id", pc_id, 32'h600);
      check("st_tgt", pred_target_id, 32'h604);
      check("st_vt", {30'b0, valid_id, pred_taken_id},
            32'h2);
    end
    PL_stall = 1'b0;

    redirect(32'hFFFF_FFFC);
    tick();
    check("wrap_pc", pc, 32'h0);
    check("wrap_tgt", pred_target_id, 32'h0);

    instr = JAL;
    tick();
    rst_n = 1'b0;
    PL_flush = 1'b1;
    PL_stall = 1'b1;
    flush_target = 32'h900;
    settle();
    check("rd_push", {31'b0, ras_push}, 32'h0);
    check("rd_rb", {30'b0, ras_rollback_push,
                    ras_rollback_pop}, 32'h0);
    tick();
    check("rd_pc", pc, 32'h0);
    check("rd_valid", {31'b0, valid_id}, 32'h0);
    check("rd_taken", {31'b0, pred_taken_id}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
